// File: rtl/video_shifter.sv
// video_shifter
//
// Bitplane video shifter. Every character period one word per bitplane is
// fetched from video RAM in fixed two-count slots. At the end of the period
// the words are moved into shift registers, and they are then serialised in
// parallel into an {R,G,B} pixel stream, one pixel per ce. In wide mode
// (pixel doubling) each pixel is held for two ce and the period is 2*DW long.
//
// Optional feature macro: VIDEO_SHIFTER_PALETTE_EN
//   defined   : 16-entry palette with a registered output (one ce extra latency),
//               writable on any clock through wr/waddr/wdata.
//   undefined : fixed mapping plane0->B, plane1->R, plane2->G, combinational;
//               wr/waddr/wdata are ignored.
//
// Parameters
//   PLANES  number of bitplanes (1..4)
//   DW      bits per fetched word, pixels per normal period (DW >= 2*PLANES+2)
//   CW      bits per output colour component
//
// Ports
//   clock   system clock
//   reset   synchronous reset, active low
//   ce      pixel clock enable
//   de      display enable, sampled in load and transfer slots
//   wide    pixel-doubling request, taken at period boundary
//   pmask   per-plane display enable
//   d       video RAM data for the plane currently addressed
//   wr      palette write strobe
//   waddr   palette index to write
//   wdata   palette entry {R,G,B}
//   rgb     output pixel {R,G,B}
//   plane   plane index the RAM arbiter must present on d
//   fetch   high while plane addresses a valid fetch slot

module video_shifter #(
  parameter int PLANES = 3,
  parameter int DW     = 8,
  parameter int CW     = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  input  logic                de,
  input  logic                wide,
  input  logic [PLANES-1:0]   pmask,
  input  logic [DW-1:0]       d,
  input  logic                wr,
  input  logic [3:0]          waddr,
  input  logic [3*CW-1:0]     wdata,
  output logic [3*CW-1:0]     rgb,
  output logic [1:0]          plane,
  output logic                fetch
);

  localparam int CNTW = $clog2(DW) + 1;
  localparam logic [CNTW-1:0] LAST_NORM = CNTW'(DW - 1);
  localparam logic [CNTW-1:0] LAST_WIDE = CNTW'(2 * DW - 1);
  localparam logic [CNTW-1:0] SLOT_END  = CNTW'(2 * PLANES);

  if (PLANES < 1 || PLANES > 4) begin : gBadPlanes
    $error("video_shifter: PLANES must be in 1..4");
  end
  // All fetch slots must finish before the transfer count, with margin.
  if (DW < 2 * PLANES + 2) begin : gBadDw
    $error("video_shifter: DW must be at least 2*PLANES+2");
  end

  // Fixed colour mapping of a pixel index; plane3 does not contribute.
  function automatic logic [3*CW-1:0] defaultColour(input logic [2:0] idx);
    return {{CW{idx[1]}}, {CW{idx[2]}}, {CW{idx[0]}}};
  endfunction

  logic [CNTW-1:0] cnt;
  logic            wideQ;
  logic [DW-1:0]   inReg [PLANES];
  logic [DW-1:0]   shReg [PLANES];
  logic [3:0]      ix;
  logic            lastCount;
  logic            shiftEn;

  // Period length follows the latched mode, so a wide request only takes
  // effect after the transfer that latches it.
  assign lastCount = (cnt == (wideQ ? LAST_WIDE : LAST_NORM));

  // In wide mode shifting on odd counts only holds each pixel for two ce.
  assign shiftEn = !wideQ || cnt[0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt   <= '0;
      wideQ <= 1'b0;
      for (int p = 0; p < PLANES; p++) begin
        inReg[p] <= '0;
        shReg[p] <= '0;
      end
    end else if (ce) begin
      if (lastCount) begin
        cnt   <= '0;
        wideQ <= wide;
      end else begin
        cnt <= cnt + CNTW'(1);
      end

      for (int p = 0; p < PLANES; p++) begin
        // Second count of the plane's slot: the arbiter has had one count
        // to put this plane's word on d.
        if (de && (cnt == CNTW'(2 * p + 1))) begin
          inReg[p] <= d;
        end

        if (lastCount) begin
          shReg[p] <= (de && pmask[p]) ? inReg[p] : '0;
        end else if (shiftEn) begin
          shReg[p] <= {shReg[p][DW-2:0], 1'b0};
        end
      end
    end
  end

  // Slot p covers counts 2p and 2p+1, so the plane index is cnt/2.
  assign fetch = (cnt < SLOT_END);
  assign plane = fetch ? cnt[2:1] : 2'b00;

  always_comb begin
    ix = '0;
    for (int p = 0; p < PLANES; p++) begin
      ix[p] = shReg[p][DW-1];
    end
  end

`ifdef VIDEO_SHIFTER_PALETTE_EN

  logic [3*CW-1:0] palette [16];
  logic [3*CW-1:0] rgbQ;

  // Writes are independent of ce. A read of an entry written on the same
  // clock sees the old contents because both use the pre-edge value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        palette[i] <= defaultColour(3'(i));
      end
      rgbQ <= '0;
    end else begin
      if (wr) begin
        palette[waddr] <= wdata;
      end
      if (ce) begin
        rgbQ <= palette[ix];
      end
    end
  end

  assign rgb = rgbQ;

`else

  assign rgb = defaultColour(ix[2:0]);

  logic unusedPalette;
  assign unusedPalette = ^{wr, waddr, wdata, ix[3]};

`endif

endmodule

// File: tb/tb_video_shifter.sv
module tb_video_shifter;

  localparam int PLANES = 3;
  localparam int DW     = 8;
  localparam int CW     = 6;
`ifdef VIDEO_SHIFTER_PALETTE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic                ce;
  logic                de;
  logic                wide;
  logic [PLANES-1:0]   pmask;
  logic [DW-1:0]       d;
  logic                wr;
  logic [3:0]          waddr;
  logic [3*CW-1:0]     wdata;
  logic [3*CW-1:0]     rgb;
  logic [1:0]          plane;
  logic                fetch;

  video_shifter #(.PLANES(PLANES), .DW(DW), .CW(CW)) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .de    (de),
    .wide  (wide),
    .pmask (pmask),
    .d     (d),
    .wr    (wr),
    .waddr (waddr),
    .wdata (wdata),
    .rgb   (rgb),
    .plane (plane),
    .fetch (fetch)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [17:0] expQ [$];
  logic [17:0] expPal [16];
  logic [7:0]  held [3];
  bit          curWide;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic primeAfterReset();
    expQ.delete();
    repeat (LAT + 8) expQ.push_back('0);
    for (int p = 0; p < 3; p++) held[p] = '0;
    curWide = 1'b0;
  endtask

  task automatic cycleCheck(input int c);
    logic [17:0] e;
    @(negedge clock);
    checkVal($sformatf("plane@%0d", c), 32'(plane), (c < 6) ? 32'(c / 2) : 32'd0);
    checkVal($sformatf("fetch@%0d", c), 32'(fetch), (c < 6) ? 32'd1 : 32'd0);
    checkVal("sbDepth", 32'(expQ.size() > 0), 32'd1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkVal($sformatf("rgb@%0d", c), 32'(rgb), 32'(e));
    end
    @(posedge clock);
    #1;
  endtask

  // Runs one full period in the current mode. Pushes the pixels the words
  // loaded now will produce next period, and checks the pixels of the words
  // loaded last period.
  task automatic doPeriod(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input logic [2:0] msk, input bit deL, input bit deT,
                          input bit wideNext, input int resetAt);
    logic [7:0] w [3];
    logic [7:0] nh [3];
    logic [3:0] ix;
    int         len;
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    len = curWide ? 16 : 8;
    for (int p = 0; p < 3; p++) nh[p] = deL ? w[p] : held[p];
    for (int k = 0; k < 8; k++) begin
      ix = {1'b0,
            nh[2][7-k] & msk[2] & deT,
            nh[1][7-k] & msk[1] & deT,
            nh[0][7-k] & msk[0] & deT};
      repeat (wideNext ? 2 : 1) expQ.push_back(expPal[ix]);
    end
    for (int c = 0; c < len; c++) begin
      d     = ((c % 2 == 1) && (c < 6)) ? w[c / 2] : 8'($urandom);
      de    = (c == len - 1) ? deT : deL;
      pmask = msk;
      wide  = (c >= len / 2) ? wideNext : curWide;
      reset = (c == resetAt) ? 1'b0 : 1'b1;
      cycleCheck(c);
      if (c == resetAt) begin
        reset = 1'b1;
        primeAfterReset();
        return;
      end
    end
    for (int p = 0; p < 3; p++) held[p] = nh[p];
    curWide = wideNext;
  endtask

  // Two clocks with ce low: the output must hold. The palette build also
  // writes entry 5 here, showing writes do not need ce.
  task automatic stallAndWrite();
    ce = 1'b0;
    @(negedge clock);
    checkVal("stallRgb", 32'(rgb), 32'(expQ[0]));
`ifdef VIDEO_SHIFTER_PALETTE_EN
    wr        = 1'b1;
    waddr     = 4'd5;
    wdata     = {6'h3F, 6'h00, 6'h15};
    expPal[5] = {6'h3F, 6'h00, 6'h15};
`endif
    @(posedge clock);
    #1;
    wr = 1'b0;
    @(negedge clock);
    checkVal("stallHold", 32'(rgb), 32'(expQ[0]));
    @(posedge clock);
    #1;
    ce = 1'b1;
  endtask

  initial begin
    logic [3:0] iv;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      expPal[i] = {{6{iv[1]}}, {6{iv[2]}}, {6{iv[0]}}};
    end

    reset = 1'b0;
    ce    = 1'b1;
    de    = 1'b0;
    wide  = 1'b0;
    pmask = '0;
    d     = '0;
    wr    = 1'b0;
    waddr = '0;
    wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    checkVal("rstRgb", 32'(rgb), 32'd0);
    checkVal("rstPlane", 32'(plane), 32'd0);
    checkVal("rstFetch", 32'(fetch), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    primeAfterReset();

    doPeriod(8'hA5, 8'hFF, 8'h00, 3'b111, 1, 1, 0, -1);
    stallAndWrite();
    doPeriod(8'hFF, 8'hFF, 8'hFF, 3'b101, 1, 1, 0, -1);
    doPeriod(8'h00, 8'hFF, 8'h00, 3'b111, 1, 1, 0, -1);
    doPeriod(8'hFF, 8'hFF, 8'hFF, 3'b111, 1, 0, 0, -1);
    doPeriod(8'hA5, 8'h00, 8'h00, 3'b111, 1, 1, 1, -1);
    doPeriod(8'hA5, 8'hFF, 8'h00, 3'b111, 1, 1, 0, -1);
    doPeriod(8'hFF, 8'hFF, 8'hFF, 3'b111, 1, 1, 0, -1);
    doPeriod(8'h12, 8'h34, 8'h56, 3'b111, 1, 1, 0, 4);
    doPeriod(8'h00, 8'h00, 8'h00, 3'b111, 0, 1, 0, -1);
    doPeriod(8'h3C, 8'hC3, 8'h5A, 3'b111, 1, 1, 0, -1);
    doPeriod(8'h00, 8'h00, 8'h00, 3'b111, 1, 1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
